// File: rtl/sc_frog_position_register_pkg.sv
// Shared constants for the Frogger control FSM and the frog position datapath.
package sc_frog_position_register_pkg;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    localparam int unsigned DEFAULT_ROWS = 8;
    localparam int unsigned DEFAULT_COLS = 8;

endpackage

// File: rtl/sc_frog_matrix_decoder.sv
// Combinational row/col/valid to one-hot playfield map; illegal indices decode to all zeros.
module sc_frog_matrix_decoder #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8,
    parameter int unsigned RW   = 3,
    parameter int unsigned CW   = 3
) (
    input  logic [RW-1:0]        row,
    input  logic [CW-1:0]        col,
    input  logic                 valid,
    output logic [ROWS*COLS-1:0] map
);

    always_comb begin
        map = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                map[r*COLS+c] = valid && (row == RW'(r)) && (col == CW'(c));
            end
        end
    end

endmodule

// File: rtl/sc_frog_position_register.sv
// Frog position/score registers with prioritised command decoding and a registered one-hot map.
module sc_frog_position_register
    import sc_frog_position_register_pkg::*;
#(
    parameter int unsigned ROWS     = DEFAULT_ROWS,
    parameter int unsigned COLS     = DEFAULT_COLS,
    parameter int unsigned INIT_COL = 3,
    parameter int unsigned SCORE_W  = 4,
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 SC_FROGPOSITION_CLOCK_50,
    input  logic                 SC_FROGPOSITION_RESET_InLow,
    input  logic                 SC_FROGPOSITION_clear_InLow,
    input  logic                 SC_FROGPOSITION_init_InLow,
    input  logic                 SC_FROGPOSITION_load0_InLow,
    input  logic                 SC_FROGPOSITION_load1_InLow,
    input  logic [1:0]           SC_FROGPOSITION_shiftselection_In,
    output logic [ROWS*COLS-1:0] SC_FROGPOSITION_matrix_Out,
    output logic [RW-1:0]        SC_FROGPOSITION_row_Out,
    output logic [CW-1:0]        SC_FROGPOSITION_col_Out,
    output logic                 SC_FROGPOSITION_valid_Out,
    output logic                 SC_FROGPOSITION_bottomsidecomparator_OutLow,
    output logic                 SC_FROGPOSITION_win_Out,
    output logic [SCORE_W-1:0]   SC_FROGPOSITION_score_Out
);

    localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_INIT = CW'(INIT_COL);

    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 valid_q, valid_d;
    logic                 win_q, win_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [ROWS*COLS-1:0] matrix_q, matrix_d;

    // Priority chain: clear > init > up > down > shift.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        score_d = score_q;
        win_d   = 1'b0;
        if (!SC_FROGPOSITION_clear_InLow) begin
            valid_d = 1'b0;
        end else if (!SC_FROGPOSITION_init_InLow) begin
            valid_d = 1'b1;
            row_d   = '0;
            col_d   = COL_INIT;
        end else if (!SC_FROGPOSITION_load0_InLow) begin
            if (valid_q) begin
                if (row_q == ROW_TOP) begin
                    row_d   = '0;
                    col_d   = COL_INIT;
                    win_d   = 1'b1;
                    score_d = score_q + SCORE_W'(1);
                end else if (row_q < ROW_TOP) begin
                    row_d = row_q + RW'(1);
                end
            end
        end else if (!SC_FROGPOSITION_load1_InLow) begin
            // Guard against a DOWN on the bottom row even though the FSM should gate it.
            if (valid_q && (row_q != '0)) begin
                row_d = row_q - RW'(1);
            end
        end else if (valid_q) begin
            unique case (SC_FROGPOSITION_shiftselection_In)
                SHIFT_LEFT: begin
                    if (col_q < COL_MAX) col_d = col_q + CW'(1);
                end
                SHIFT_RIGHT: begin
                    if (col_q != '0) col_d = col_q - CW'(1);
                end
                SHIFT_HOLD, 2'b00: ;
            endcase
        end
    end

    sc_frog_matrix_decoder #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_decoder (
        .row   (row_d),
        .col   (col_d),
        .valid (valid_d),
        .map   (matrix_d)
    );

    always_ff @(posedge SC_FROGPOSITION_CLOCK_50 or negedge SC_FROGPOSITION_RESET_InLow) begin
        if (!SC_FROGPOSITION_RESET_InLow) begin
            row_q    <= '0;
            col_q    <= COL_INIT;
            valid_q  <= 1'b0;
            win_q    <= 1'b0;
            score_q  <= '0;
            matrix_q <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            valid_q  <= valid_d;
            win_q    <= win_d;
            score_q  <= score_d;
            matrix_q <= matrix_d;
        end
    end

    assign SC_FROGPOSITION_matrix_Out = matrix_q;
    assign SC_FROGPOSITION_row_Out    = row_q;
    assign SC_FROGPOSITION_col_Out    = col_q;
    assign SC_FROGPOSITION_valid_Out  = valid_q;
    assign SC_FROGPOSITION_win_Out    = win_q;
    assign SC_FROGPOSITION_score_Out  = score_q;
    assign SC_FROGPOSITION_bottomsidecomparator_OutLow = ~(valid_q && (row_q == '0));

endmodule

// File: tb/tb_sc_frog_position_register.sv
// Scoreboard bench: directed plan plus random commands against a rule-level reference model.
module tb_sc_frog_position_register;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int INIT_COL = 3;
    localparam int SCORE_W = 4;

    typedef struct {
        logic [63:0] matrix;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        valid;
        logic        bsc;
        logic        win;
        logic [3:0]  score;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_n = 1'b1;
    logic        ini_n = 1'b1;
    logic        l0_n = 1'b1;
    logic        l1_n = 1'b1;
    logic [1:0]  sh = 2'b00;
    logic [63:0] matrix;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        valid;
    logic        bsc;
    logic        win;
    logic [3:0]  score;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state kept as plain integers.
    int m_row = 0;
    int m_col = INIT_COL;
    int m_score = 0;
    bit m_valid = 1'b0;
    bit m_win = 1'b0;

    sc_frog_position_register #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .INIT_COL (INIT_COL),
        .SCORE_W  (SCORE_W)
    ) dut (
        .SC_FROGPOSITION_CLOCK_50                    (clk),
        .SC_FROGPOSITION_RESET_InLow                 (rst_n),
        .SC_FROGPOSITION_clear_InLow                 (clr_n),
        .SC_FROGPOSITION_init_InLow                  (ini_n),
        .SC_FROGPOSITION_load0_InLow                 (l0_n),
        .SC_FROGPOSITION_load1_InLow                 (l1_n),
        .SC_FROGPOSITION_shiftselection_In           (sh),
        .SC_FROGPOSITION_matrix_Out                  (matrix),
        .SC_FROGPOSITION_row_Out                     (row),
        .SC_FROGPOSITION_col_Out                     (col),
        .SC_FROGPOSITION_valid_Out                   (valid),
        .SC_FROGPOSITION_bottomsidecomparator_OutLow (bsc),
        .SC_FROGPOSITION_win_Out                     (win),
        .SC_FROGPOSITION_score_Out                   (score)
    );

    always #5 clk = ~clk;

    function automatic void model(bit rst, bit clr, bit ini, bit l0, bit l1, logic [1:0] s);
        m_win = 1'b0;
        if (!rst) begin
            m_valid = 1'b0; m_row = 0; m_col = INIT_COL; m_score = 0;
        end else if (!clr) begin
            m_valid = 1'b0;
        end else if (!ini) begin
            m_valid = 1'b1; m_row = 0; m_col = INIT_COL;
        end else if (!l0) begin
            if (m_valid) begin
                if (m_row == ROWS - 1) begin
                    m_row = 0; m_col = INIT_COL; m_win = 1'b1;
                    m_score = (m_score + 1) % (1 << SCORE_W);
                end else begin
                    m_row = m_row + 1;
                end
            end
        end else if (!l1) begin
            if (m_valid && m_row > 0) m_row = m_row - 1;
        end else if (m_valid) begin
            if (s == 2'b01 && m_col < COLS - 1) m_col = m_col + 1;
            else if (s == 2'b10 && m_col > 0) m_col = m_col - 1;
        end
    endfunction

    function automatic exp_t cur_exp();
        exp_t e;
        e.matrix = m_valid ? (64'd1 << (m_row * COLS + m_col)) : 64'd0;
        e.row    = 3'(m_row);
        e.col    = 3'(m_col);
        e.valid  = m_valid;
        e.bsc    = !(m_valid && m_row == 0);
        e.win    = m_win;
        e.score  = 4'(m_score);
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        checks++;
        if (matrix !== e.matrix || row !== e.row || col !== e.col || valid !== e.valid ||
            bsc !== e.bsc || win !== e.win || score !== e.score) begin
            errors++;
            $display("FAIL %s t=%0t got m=%h r=%0d c=%0d v=%b b=%b w=%b s=%0d want m=%h r=%0d c=%0d v=%b b=%b w=%b s=%0d",
                     name, $time, matrix, row, col, valid, bsc, win, score,
                     e.matrix, e.row, e.col, e.valid, e.bsc, e.win, e.score);
        end
    endtask

    // Monitor: outputs are presented every edge; compare 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check_out("edge", exp_q.pop_front());
        end
    end

    task automatic step(input bit rst, input bit clr, input bit ini, input bit l0, input bit l1,
                        input logic [1:0] s);
        @(negedge clk);
        rst_n = rst; clr_n = clr; ini_n = ini; l0_n = l0; l1_n = l1; sh = s;
        model(rst, clr, ini, l0, l1, s);
        exp_q.push_back(cur_exp());
        // Reset takes effect without waiting for an edge.
        if (!rst) begin
            #1;
            check_out("async_reset", cur_exp());
        end
    endtask

    task automatic cmd(input bit clr, input bit ini, input bit l0, input bit l1,
                       input logic [1:0] s);
        step(1'b1, clr, ini, l0, l1, s);
    endtask

    task automatic idle();
        cmd(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic up();
        cmd(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    endtask

    task automatic init_frog();
        cmd(1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    endtask

    initial begin
        // 1: reset, then ignored commands while not valid
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        idle();
        up();
        cmd(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
        // 2: init, then down on bottom row
        init_frog();
        cmd(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        // 3: climb to top and cross
        init_frog();
        repeat (8) up();
        idle();
        // 4: shift saturation both ways
        init_frog();
        repeat (5) cmd(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
        repeat (9) cmd(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        // 5: priority
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        cmd(1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        // 6: sixteen crossings wrap the score, then reset during a win
        repeat (16) begin
            init_frog();
            repeat (8) up();
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        idle();
        init_frog();
        repeat (7) up();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        idle();
        // Random phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 24) != 0),
                 ($urandom_range(0, 11) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end
        idle();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_frog_position_register.md
Name: sc_frog_position_register

Overview:
- Datapath stage directly downstream of the Frogger control state machine.
- Consumes its active-low clear/init/load0/load1 strobes and its 2-bit shift selection, and holds the frog's row/column position on the playfield grid.
- Drives a registered one-hot frog matrix to the display merger, a win pulse and score count to game control.
- Drives the active-low bottom-side comparator flag back to the state machine, so DOWN is suppressed on the bottom row.

Parameters:
- ROWS, 8, number of playfield rows; row 0 is the bottom (start) row.
- COLS, 8, number of playfield columns.
- INIT_COL, 3, column the frog occupies after init or after a win respawn.
- SCORE_W, 4, width of the win counter.

Ports:
- SC_FROGPOSITION_CLOCK_50  input  1  system clock, all state updates on its rising edge.
- SC_FROGPOSITION_RESET_InLow  input  1  asynchronous active-low reset.
- SC_FROGPOSITION_clear_InLow  input  1  remove frog from grid (0 = active).
- SC_FROGPOSITION_init_InLow  input  1  place frog at start position (0 = active).
- SC_FROGPOSITION_load0_InLow  input  1  move up one row (0 = active).
- SC_FROGPOSITION_load1_InLow  input  1  move down one row (0 = active).
- SC_FROGPOSITION_shiftselection_In  input  2  01 = left, 10 = right, 00/11 = hold.
- SC_FROGPOSITION_matrix_Out  output  ROWS*COLS  one-hot frog map; bit index row*COLS+col.
- SC_FROGPOSITION_row_Out  output  clog2(ROWS)  current row index.
- SC_FROGPOSITION_col_Out  output  clog2(COLS)  current column index.
- SC_FROGPOSITION_valid_Out  output  1  frog present on grid.
- SC_FROGPOSITION_bottomsidecomparator_OutLow  output  1  0 when valid and row==0, else 1.
- SC_FROGPOSITION_win_Out  output  1  one-cycle pulse on successful crossing.
- SC_FROGPOSITION_score_Out  output  SCORE_W  number of wins, modulo 2^SCORE_W.

Behaviour:
- Reset (async assert, release synchronous to next edge):
  - valid=0, row=0, col=INIT_COL, matrix=all 0.
  - win=0, score=0, bottomsidecomparator=1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Command priority per cycle: clear > init > up (load0) > down (load1) > shift. Lower-priority commands in the same cycle are ignored.
- Command effects, all applied at the rising edge:
  - clear: valid=0. Row and col keep their values. Score is unchanged.
  - init: valid=1, row=0, col=INIT_COL. Score is unchanged.
  - up, valid=1, row<ROWS-1: row=row+1.
  - up, valid=1, row==ROWS-1: row=0, col=INIT_COL, win=1 for exactly this cycle, score=score+1 (wraps 2^SCORE_W-1 to 0).
  - down, valid=1: row>0 gives row=row-1; row==0 leaves row unchanged. This is a defensive guard even though the FSM gates on the comparator.
  - left, valid=1: col=col+1, saturating at COLS-1, no wrap.
  - right, valid=1: col=col-1, saturating at 0, no wrap.
- With valid=0, up/down/shift are ignored: no position change, no win.
- win_Out is low on every cycle without a winning up. The FSM issues one strobe per press, so a held strobe produces a win only on the cycle it reaches the top row.
- Latency and output timing:
  - A command sampled at edge N is reflected on every output after edge N.
  - All outputs are registered: matrix, row, col, valid, win, score.
  - The comparator is derived from registered row/valid only; no combinational path from inputs to outputs.
- Matrix content: exactly one bit set at row*COLS+col when valid=1; all zero when valid=0.
- Reset asserted mid-operation overrides everything immediately, including a pending win pulse and the score.
- Row/col outside legal range cannot occur. If one is forced, the next init restores legality; the matrix shows zeros for illegal indices.

Decomposition:
- Shared package:
  - SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_HOLD=2'b11 (00 treated as hold).
  - Default ROWS/COLS.
  - Shared by the FSM and this block.
- Sub-module sc_frog_matrix_decoder: combinational row/col/valid to one-hot ROWS*COLS map. Its output is registered in the parent.
- Position/score registers and command priority logic stay in the parent.

Test Plan:
1. Reset low, then release.
   -> matrix=0, valid=0, bottomsidecomparator=1, score=0. Then load0 and shift=01 pulses cause no change.
2. init pulse.
   -> next cycle: valid=1, row=0, col=3, matrix bit 3 set, bottomsidecomparator=0.
   Then load1 pulse -> row stays 0.
3. After init, 7 single-cycle load0 pulses.
   -> row=7, matrix bit 59.
   8th pulse -> row=0, col=3, win=1 for one cycle, score=1.
4. After init, 5 pulses shift=01.
   -> col=4,5,6,7,7 (saturates).
   Then 9 pulses shift=10 -> col decrements to 0 and holds.
5. Same cycle: init_InLow=0, clear_InLow=0, load0_InLow=0.
   -> valid=0, matrix=0 (clear wins).
   Next: init with shift=01 concurrently -> row=0, col=3 (init wins).
6. Score wrap and reset mid-win: 16 crossings -> score wraps 15 to 0.
   Assert reset in the same cycle as a winning load0 -> win stays 0, score=0, valid=0.
